// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_if
// Brief   : Instruction/data request ports and the shared RAM port of the arbiter.
// Rev     : 1.0
// ============================================================================
interface mem_arbiter_if;
    // Instruction port
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    // Data port
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    // RAM port; ramstate: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    // Arbiter view: answers the requesters and drives the RAM.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

    // Environment view: the requesters plus the RAM model.
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-port (instruction/data) arbiter onto one RAM, data-priority;
//           optional starvation guard enabled by macro ARB_STARVE_GUARD_EN.
// Rev     : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic     CLK,
    input  wire logic     nRST,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   data_req;
    logic   ram_done;
    logic   instr_first;

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end

    assign data_req = bus.dREN | bus.dWEN;
    assign ram_done = (bus.ramstate == RAM_ACCESS);

`ifdef ARB_STARVE_GUARD_EN
    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;

    // Once the data port has won STARVE_LIMIT grants in a row, a waiting fetch goes first.
    assign instr_first = bus.iREN && (starve_q == CNT_MAX);

    always_comb begin
        starve_d = starve_q;
        if (!bus.iREN || (state_q == IDLE && state_d == INSTR)) begin
            starve_d = '0;
        end else if (state_q == IDLE && state_d == DATA && starve_q != CNT_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end
`else
    assign instr_first = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (instr_first) begin
                    state_d = INSTR;
                end else if (data_req) begin
                    state_d = DATA;
                end else if (bus.iREN) begin
                    state_d = INSTR;
                end
            end
            // A withdrawn request ends the grant just like a completed one.
            DATA: begin
                if (!data_req || ram_done) begin
                    state_d = IDLE;
                end
            end
            INSTR: begin
                if (!bus.iREN || ram_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
`ifdef ARB_STARVE_GUARD_EN
            starve_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q <= starve_d;
`endif
        end
    end

    // RAM controls decode straight from the registered state so that reset clears
    // them without a clock and a dropped request removes its strobe in the same cycle.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state_q)
            DATA: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
            end
            INSTR: begin
                bus.ramaddr  = bus.iaddr;
                bus.ramREN   = bus.iREN;
            end
            default: begin
            end
        endcase
    end

    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;
    assign bus.dwait = data_req & ~((state_q == DATA) & ram_done);
    assign bus.iwait = bus.iREN & ~((state_q == INSTR) & ram_done);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed scenarios plus random traffic against a grant-level model.
// Rev     : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int         LIMIT     = 4;
    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Grant-level model: who owns the RAM (0 nobody, 1 data port, 2 instruction port)
    // and how many data grants have passed a waiting fetch.
    int owner  = 0;
    int starve = 0;

    task automatic check_outputs(input string where);
        logic        dreq;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        dreq    = bus.dREN | bus.dWEN;
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_addr  = 32'h0;
        e_store = 32'h0;
        if (owner == 1) begin
            e_addr  = bus.daddr;
            e_store = bus.dstore;
            e_wen   = bus.dWEN;
            e_ren   = bus.dREN && !bus.dWEN;
        end else if (owner == 2) begin
            e_addr = bus.iaddr;
            e_ren  = bus.iREN;
        end
        check_value({where, ".ramREN"},   32'(bus.ramREN),  32'(e_ren));
        check_value({where, ".ramWEN"},   32'(bus.ramWEN),  32'(e_wen));
        check_value({where, ".ramaddr"},  bus.ramaddr,      e_addr);
        check_value({where, ".ramstore"}, bus.ramstore,     e_store);
        check_value({where, ".dwait"},    32'(bus.dwait),
                    32'((owner == 1 && bus.ramstate == ST_ACCESS) ? 1'b0 : dreq));
        check_value({where, ".iwait"},    32'(bus.iwait),
                    32'((owner == 2 && bus.ramstate == ST_ACCESS) ? 1'b0 : bus.iREN));
        check_value({where, ".dload"},    bus.dload, bus.ramload);
        check_value({where, ".iload"},    bus.iload, bus.ramload);
    endtask

    task automatic model_advance();
        int   nxt;
        logic dreq;
        dreq = bus.dREN | bus.dWEN;
        nxt  = owner;
        if (owner == 0) begin
            if (GUARD && bus.iREN && starve == LIMIT) nxt = 2;
            else if (dreq)                            nxt = 1;
            else if (bus.iREN)                        nxt = 2;
        end else if (owner == 1) begin
            if (!dreq || bus.ramstate == ST_ACCESS) nxt = 0;
        end else begin
            if (!bus.iREN || bus.ramstate == ST_ACCESS) nxt = 0;
        end
        if (GUARD) begin
            if (!bus.iREN || (owner == 0 && nxt == 2)) starve = 0;
            else if (owner == 0 && nxt == 1 && starve < LIMIT) starve++;
        end
        owner = nxt;
    endtask

    // Stimulus changes 1 time unit after a rising edge; outputs are checked 2 units later.
    task automatic settle(input string where);
        #2;
        check_outputs(where);
    endtask

    task automatic tick();
        @(posedge CLK);
        if (nRST) model_advance();
        #1;
    endtask

    task automatic clear_inputs();
        bus.iREN     = 1'b0;
        bus.iaddr    = 32'h0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'h0;
        bus.dstore   = 32'h0;
        bus.ramload  = 32'h0;
        bus.ramstate = ST_FREE;
    endtask

    task automatic do_reset();
        nRST   = 1'b0;
        owner  = 0;
        starve = 0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic randomize_inputs();
        int r;
        bus.iREN    = ($urandom_range(99) < 70);
        bus.dREN    = ($urandom_range(99) < 60);
        bus.dWEN    = ($urandom_range(99) < 35);
        bus.iaddr   = $urandom;
        bus.daddr   = $urandom;
        bus.dstore  = $urandom;
        bus.ramload = $urandom;
        r = $urandom_range(99);
        if (r < 40)      bus.ramstate = ST_ACCESS;
        else if (r < 70) bus.ramstate = ST_BUSY;
        else if (r < 85) bus.ramstate = ST_FREE;
        else             bus.ramstate = ST_ERROR;
    endtask

    initial begin
        int igrants;
        int dgrants;

        // Reset state: strobes low, waits mirror the raw requests.
        clear_inputs();
        nRST = 1'b0;
        bus.iREN = 1'b1;
        bus.dWEN = 1'b1;
        #3;
        check_outputs("in_reset");
        check_value("in_reset.dwait_const", 32'(bus.dwait), 32'd1);
        clear_inputs();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        settle("after_reset");
        tick();

        // Instruction read completing one cycle after grant.
        bus.iREN = 1'b1; bus.iaddr = 32'h0000_0040; bus.ramload = 32'h2108_0001;
        settle("rd_idle");
        tick();
        bus.ramstate = ST_ACCESS;
        settle("rd_instr");
        check_value("rd.ramREN",  32'(bus.ramREN), 32'd1);
        check_value("rd.ramaddr", bus.ramaddr,     32'h40);
        check_value("rd.iwait",   32'(bus.iwait),  32'd0);
        check_value("rd.iload",   bus.iload,       32'h2108_0001);
        tick();
        bus.iREN = 1'b0; bus.ramstate = ST_FREE;
        settle("rd_done");
        tick();

        // Contention: data write wins, fetch follows after one idle cycle.
        bus.iREN = 1'b1; bus.iaddr = 32'h80;
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
        bus.ramstate = ST_BUSY;
        settle("ct_idle");
        tick();
        settle("ct_data_busy");
        check_value("ct.ramWEN",   32'(bus.ramWEN), 32'd1);
        check_value("ct.ramREN",   32'(bus.ramREN), 32'd0);
        check_value("ct.ramstore", bus.ramstore,    32'hDEAD_BEEF);
        check_value("ct.iwait_b",  32'(bus.iwait),  32'd1);
        tick();
        bus.ramstate = ST_ACCESS;
        settle("ct_data_acc");
        check_value("ct.dwait_acc", 32'(bus.dwait), 32'd0);
        check_value("ct.iwait_acc", 32'(bus.iwait), 32'd1);
        tick();
        bus.dWEN = 1'b0; bus.ramstate = ST_FREE;
        settle("ct_gap");
        check_value("ct.gap_ramREN", 32'(bus.ramREN), 32'd0);
        tick();
        bus.ramstate = ST_ACCESS;
        settle("ct_instr");
        check_value("ct.instr_ramREN",  32'(bus.ramREN), 32'd1);
        check_value("ct.instr_ramaddr", bus.ramaddr,     32'h80);
        tick();
        bus.iREN = 1'b0; bus.ramstate = ST_FREE;
        settle("ct_end");
        tick();

        // Three BUSY cycles then ACCESS on a data read.
        bus.dREN = 1'b1; bus.daddr = 32'h200; bus.ramstate = ST_BUSY;
        settle("ws_idle");
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.ramstate = ST_ACCESS;
            settle("ws_data");
            check_value("ws.dwait",   32'(bus.dwait), (i == 3) ? 32'd0 : 32'd1);
            check_value("ws.ramaddr", bus.ramaddr,    32'h200);
            tick();
        end
        bus.dREN = 1'b0; bus.ramstate = ST_FREE;
        settle("ws_end");
        tick();

        // Withdrawn fetch drops its strobe in the same cycle.
        bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = ST_BUSY;
        settle("wd_idle");
        tick();
        bus.iREN = 1'b0;
        settle("wd_instr");
        check_value("wd.ramREN", 32'(bus.ramREN), 32'd0);
        tick();
        settle("wd_after");
        tick();

        // Asynchronous reset in the middle of a stalled data access.
        bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = ST_BUSY;
        settle("ar_idle");
        tick();
        settle("ar_data");
        nRST = 1'b0;
        #1;
        check_value("ar.ramREN",  32'(bus.ramREN), 32'd0);
        check_value("ar.ramWEN",  32'(bus.ramWEN), 32'd0);
        check_value("ar.ramaddr", bus.ramaddr,     32'h0);
        check_value("ar.dwait",   32'(bus.dwait),  32'd1);
        owner  = 0;
        starve = 0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        bus.dREN = 1'b0;
        settle("ar_release");
        tick();

        // Both ports requesting continuously with an always-ready RAM.
        do_reset();
        bus.iREN = 1'b1; bus.iaddr = 32'h400;
        bus.dREN = 1'b1; bus.daddr = 32'h600;
        bus.ramstate = ST_ACCESS;
        igrants = 0;
        dgrants = 0;
        for (int i = 0; i < 20; i++) begin
            settle("sv");
            if (bus.ramREN && bus.ramaddr == 32'h400) igrants++;
            if (bus.ramREN && bus.ramaddr == 32'h600) dgrants++;
            tick();
        end
        check_value("sv.instr_grants", 32'(igrants), GUARD ? 32'd2 : 32'd0);
        check_value("sv.data_grants",  32'(dgrants), GUARD ? 32'd8 : 32'd10);

        // Random traffic, including ERROR retries and mid-transaction withdrawals.
        clear_inputs();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            settle("rnd");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: number of consecutive data grants allowed while an instruction request waits (used only with ARB_STARVE_GUARD_EN).
REQ-002 SHALL have port CLK  input  1  clock, rising-edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iREN  input  1  instruction fetch request.
REQ-005 SHALL have port iaddr  input  32  instruction address.
REQ-006 SHALL have port iload  output  32  instruction data.
REQ-007 SHALL have port iwait  output  1  instruction request not yet complete.
REQ-008 SHALL have port dREN  input  1  data read request.
REQ-009 SHALL have port dWEN  input  1  data write request.
REQ-010 SHALL have port daddr  input  32  data address.
REQ-011 SHALL have port dstore  input  32  data write value.
REQ-012 SHALL have port dload  output  32  data read value.
REQ-013 SHALL have port dwait  output  1  data request not yet complete.
REQ-014 SHALL have ports ramREN, ramWEN  output  1 each  RAM read/write strobes.
REQ-015 SHALL have ports ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-016 SHALL have port ramload  input  32  RAM read data.
REQ-017 SHALL have port ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Function
REQ-018 SHALL implement an FSM with states IDLE, DATA and INSTR.
REQ-019 In IDLE, SHALL drive no RAM strobes and SHALL arbitrate for the next state:
- (dREN|dWEN) -> DATA, else iREN -> INSTR, else stay in IDLE.
REQ-020 In DATA, SHALL drive ramaddr=daddr, ramstore=dstore and ramWEN=dWEN.
- ramREN=dREN&!dWEN: when both are asserted, the write wins.
REQ-021 In INSTR, SHALL drive ramaddr=iaddr, ramREN=1 and ramWEN=0.
REQ-022 dload and iload SHALL be combinational copies of ramload at all times.
REQ-023 Wait outputs:
- dwait SHALL be 0 only when state==DATA and ramstate==ACCESS.
- iwait SHALL be 0 only when state==INSTR and ramstate==ACCESS.
- Otherwise each wait SHALL equal its own request (dREN|dWEN for dwait, iREN for iwait).
REQ-024 On ramstate==ACCESS in DATA or INSTR, SHALL return to IDLE next cycle.
- Minimum transaction latency: 2 cycles from request to completion.
- One idle cycle occurs between back-to-back grants.
REQ-025 On ramstate BUSY, FREE or ERROR, SHALL hold the current state and outputs.
- ERROR is retried indefinitely.
REQ-026 If the granted requester deasserts its request before ACCESS, SHALL return to IDLE next cycle and drop the RAM strobes in that cycle.
REQ-027 SHALL never assert ramREN and ramWEN in the same cycle.

Reset
REQ-028 On nRST low, asynchronously and regardless of in-flight transaction:
- state=IDLE, starvation counter=0.
- ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- iwait and dwait follow their requests per REQ-023.
REQ-029 The first arbitration after reset release SHALL occur on the first rising CLK edge with nRST high.

Configuration
REQ-030 Macro ARB_STARVE_GUARD_EN, when defined, SHALL add a counter of width clog2(STARVE_LIMIT+1) bits:
- increments on each IDLE->DATA grant while iREN=1.
- clears on an IDLE->INSTR grant or whenever iREN=0.
- saturates at STARVE_LIMIT.
REQ-031 With ARB_STARVE_GUARD_EN defined and counter==STARVE_LIMIT, IDLE SHALL grant INSTR whenever iREN=1, even if a data request is present.
REQ-032 Without ARB_STARVE_GUARD_EN, SHALL use strict data priority per REQ-019 with no counter logic.

Verification
REQ-033 Read path: iREN=1, iaddr=0x0000_0040, ramstate=ACCESS one cycle after grant, ramload=0x2108_0001:
- ramREN=1 and ramaddr=0x40 in INSTR.
- iwait=0 and iload=0x2108_0001 in that cycle.
REQ-034 Contention: iREN=1 and dWEN=1 together, daddr=0x100, dstore=0xDEAD_BEEF:
- DATA granted first with ramWEN=1 and ramstore=0xDEADBEEF.
- INSTR granted after completion plus one IDLE cycle.
- iwait=1 throughout the data transaction.
REQ-035 Wait states: ramstate=BUSY for 3 cycles then ACCESS on a data read:
- dwait=1 for the 3 BUSY cycles and 0 on ACCESS.
- ramaddr stable across all 4 cycles.
REQ-036 Reset mid-operation: nRST pulsed low during DATA with ramstate=BUSY:
- ramREN, ramWEN and ramaddr go to 0 immediately, without a clock edge.
- State is IDLE after release.
REQ-037 With ARB_STARVE_GUARD_EN defined, STARVE_LIMIT=4, iREN and dREN held high continuously:
- Exactly 4 data grants, then 1 instruction grant, repeating.
- Without the macro, the instruction request is never granted.
